issue_stage: RTL

- Operand-issue stage on the producer side of the execute interface.
- Accepts decoded instructions and reads RegData1/RegData2 from the register file.
- Tracks pending writes in an 8-entry scoreboard and stalls on RAW/WAW hazards.
- Delivers operands to execute through a registered valid/ready handshake; clears scoreboard bits when writeback returns results.

---
 rtl/issue_stage.sv | 100 ++++++++++
 1 files changed

// File: rtl/issue_stage.sv
// issue_stage: operand-issue stage with 8-entry write scoreboard, RAW/WAW stall and registered execute handshake.
// Optional writeback forwarding is enabled by defining ISSUE_WB_FWD_EN.
module issue_stage #(
    parameter int N    = 16,
    parameter int NREG = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    instruction,
    input  logic [2:0]      rs_sel,
    input  logic [2:0]      rt_sel,
    input  logic [2:0]      rd_sel,
    input  logic            uses_rs,
    input  logic            uses_rt,
    input  logic            rd_we,
    output logic [2:0]      rf_addr1,
    output logic [2:0]      rf_addr2,
    input  logic [N-1:0]    rf_data1,
    input  logic [N-1:0]    rf_data2,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [N-1:0]    ex_instruction,
    output logic [N-1:0]    ex_RegData1,
    output logic [N-1:0]    ex_RegData2,
    output logic [2:0]      ex_rd_sel,
    output logic            ex_rd_we,
    input  logic            wb_valid,
    input  logic [2:0]      wb_sel,
    input  logic [N-1:0]    wb_data,
    input  logic            flush,
    output logic [CNTW-1:0] stall_cnt
);
    logic [NREG-1:0] sb, sb_eff, sb_next, wb_hit, squash_hit, issue_hit;
    logic [N-1:0]    op1, op2;
    logic            hazard, space, issue, squash, stalling;

    assign rf_addr1 = rs_sel;
    assign rf_addr2 = rt_sel;

    // Hazard detection, handshake and next scoreboard; set beats any same-cycle clear.
    always_comb begin
        wb_hit     = wb_valid ? (NREG'(1) << wb_sel) : '0;
`ifdef ISSUE_WB_FWD_EN
        sb_eff     = sb & ~wb_hit;
        op1        = (wb_valid && wb_sel == rs_sel) ? wb_data : rf_data1;
        op2        = (wb_valid && wb_sel == rt_sel) ? wb_data : rf_data2;
`else
        sb_eff     = sb;
        op1        = rf_data1;
        op2        = rf_data2;
`endif
        hazard     = (uses_rs & sb_eff[rs_sel]) | (uses_rt & sb_eff[rt_sel]) | (rd_we & sb_eff[rd_sel]);
        space      = !ex_valid | ex_ready;
        in_ready   = space & !hazard & !flush;
        issue      = in_valid & in_ready;
        squash     = flush & ex_valid & ex_rd_we & !ex_ready;
        stalling   = in_valid & space & hazard & !flush;
        squash_hit = squash ? (NREG'(1) << ex_rd_sel) : '0;
        issue_hit  = (issue & rd_we) ? (NREG'(1) << rd_sel) : '0;
        sb_next    = (sb & ~wb_hit & ~squash_hit) | issue_hit;
    end

    // Operand register: flush squashes, issue loads, consume empties while data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_instruction <= '0;
            ex_RegData1    <= '0;
            ex_RegData2    <= '0;
            ex_rd_sel      <= '0;
            ex_rd_we       <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid       <= 1'b1;
            ex_instruction <= instruction;
            ex_RegData1    <= op1;
            ex_RegData2    <= op2;
            ex_rd_sel      <= rd_sel;
            ex_rd_we       <= rd_we;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Scoreboard of registers with writes in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb <= '0;
        else        sb <= sb_next;
    end

    // Saturating count of cycles lost to hazards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        stall_cnt <= '0;
        else if (stalling && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
